// File: rtl/pmod_ts_pkg.sv
// Shared definitions for the PMOD timestamp pulse generator.
//  - state encoding of the per-channel pulse FSM (IDLE / PULSE / GAP)
//  - pin_level(): maps "pulse asserted" onto the physical pin level for a given polarity
//  - width helpers used to size the down-counter and the pending-trigger counter
package pmod_ts_pkg;

   typedef logic [1:0] ts_state_t;

   localparam ts_state_t ST_IDLE  = 2'd0;
   localparam ts_state_t ST_PULSE = 2'd1;
   localparam ts_state_t ST_GAP   = 2'd2;

   // Bits needed to hold values 0..n-1, never less than one bit.
   function automatic int width_of(input int n);
      if (n <= 1) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

   function automatic int max_of(input int a, input int b);
      if (a > b) begin
         return a;
      end else begin
         return b;
      end
   endfunction

   // Physical pin level: an active-low pin is driven 0 while the pulse is asserted.
   function automatic logic pin_level(input logic active_low, input logic asserted);
      return asserted ^ active_low;
   endfunction

endpackage

// File: rtl/pmod_ts_channel.sv
// One timestamp channel: IDLE/PULSE/GAP FSM with a shared down-counter,
// pending-trigger counter, sticky overflow, pulse counter and start timestamp.
// Ports:
//  sys_clock  in   clock
//  reset      in   asynchronous active-low reset
//  enable     in   global trigger enable (0 flushes pending, ignores trig)
//  trig       in   one event per high cycle
//  clear_ovf  in   clears overflow (a same-cycle drop wins)
//  ts_now     in   shared free-running timestamp
//  pmod_pin   out  registered pulse pin
//  busy       out  registered: in PULSE/GAP or pending>0
//  overflow   out  registered sticky drop flag
//  pulse_cnt  out  pulses started (wraps)
//  ts_last    out  ts_now in the cycle the last pulse start was decided
module pmod_ts_channel
   import pmod_ts_pkg::*;
#(
   parameter int PULSE_CYCLES = 100,
   parameter int GAP_CYCLES   = 100,
   parameter int PEND_DEPTH   = 4,
   parameter int TS_WIDTH     = 32,
   parameter int CNT_WIDTH    = 16,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic                 sys_clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 trig,
   input  logic                 clear_ovf,
   input  logic [TS_WIDTH-1:0]  ts_now,
   output logic                 pmod_pin,
   output logic                 busy,
   output logic                 overflow,
   output logic [CNT_WIDTH-1:0] pulse_cnt,
   output logic [TS_WIDTH-1:0]  ts_last
);

   localparam int DW = max_of(width_of(PULSE_CYCLES), width_of(GAP_CYCLES));
   localparam int PW = width_of(PEND_DEPTH + 1);
   localparam logic HAS_GAP = (GAP_CYCLES > 0);
   localparam logic AL      = (ACTIVE_LOW != 0);

   localparam logic [DW-1:0] DCNT_ZERO  = {DW{1'b0}};
   localparam logic [DW-1:0] DCNT_ONE   = DW'(1);
   localparam logic [DW-1:0] PULSE_LOAD = DW'(PULSE_CYCLES - 1);
   // With no gap state the load value is never used.
   localparam logic [DW-1:0] GAP_LOAD   = HAS_GAP ? DW'(GAP_CYCLES - 1) : DCNT_ZERO;

   localparam logic [PW-1:0] PEND_ZERO = {PW{1'b0}};
   localparam logic [PW-1:0] PEND_ONE  = PW'(1);
   localparam logic [PW-1:0] PEND_MAX  = PW'(PEND_DEPTH);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   ts_state_t           state_r, state_s;
   logic [DW-1:0]       dcnt_r, dcnt_s;
   logic [PW-1:0]       pend_r, pend_s;
   logic                ovf_r, ovf_s;
   logic                pin_r;
   logic                busy_r;
   logic [CNT_WIDTH-1:0] cnt_r;
   logic [TS_WIDTH-1:0] ts_r;
   logic                accept_s;
   logic                start_s;
   logic                drop_s;

   // Next-state logic: FSM, down-counter, pending queue and overflow.
   always_comb begin
      accept_s = trig & enable;
      state_s  = state_r;
      dcnt_s   = dcnt_r;
      pend_s   = pend_r;
      start_s  = 1'b0;
      drop_s   = 1'b0;

      case (state_r)
         ST_IDLE: begin
            // A queued trigger starts only while enabled (disable flushes the queue).
            if (accept_s || (enable && (pend_r != PEND_ZERO))) begin
               start_s = 1'b1;
               state_s = ST_PULSE;
               dcnt_s  = PULSE_LOAD;
               // Consume one queued event unless a new one replaces it this cycle.
               if ((pend_r != PEND_ZERO) && !accept_s) begin
                  pend_s = pend_r - PEND_ONE;
               end else begin
                  pend_s = pend_r;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_PULSE: begin
            if (accept_s) begin
               if (pend_r < PEND_MAX) begin
                  pend_s = pend_r + PEND_ONE;
               end else begin
                  drop_s = 1'b1;
               end
            end else begin
               pend_s = pend_r;
            end
            if (dcnt_r == DCNT_ZERO) begin
               if (HAS_GAP) begin
                  state_s = ST_GAP;
                  dcnt_s  = GAP_LOAD;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               dcnt_s = dcnt_r - DCNT_ONE;
            end
         end
         ST_GAP: begin
            if (accept_s) begin
               if (pend_r < PEND_MAX) begin
                  pend_s = pend_r + PEND_ONE;
               end else begin
                  drop_s = 1'b1;
               end
            end else begin
               pend_s = pend_r;
            end
            if (dcnt_r == DCNT_ZERO) begin
               state_s = ST_IDLE;
            end else begin
               dcnt_s = dcnt_r - DCNT_ONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
            dcnt_s  = DCNT_ZERO;
            pend_s  = PEND_ZERO;
         end
      endcase

      if (!enable) begin
         pend_s = PEND_ZERO;
      end else begin
         pend_s = pend_s;
      end

      // A drop in the same cycle outranks the clear request.
      if (drop_s) begin
         ovf_s = 1'b1;
      end else if (clear_ovf) begin
         ovf_s = 1'b0;
      end else begin
         ovf_s = ovf_r;
      end
   end

   // State and output registers; reset forces the pin to its idle level at once.
   always_ff @(posedge sys_clock or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         dcnt_r  <= DCNT_ZERO;
         pend_r  <= PEND_ZERO;
         ovf_r   <= 1'b0;
         pin_r   <= pin_level(AL, 1'b0);
         busy_r  <= 1'b0;
         cnt_r   <= {CNT_WIDTH{1'b0}};
         ts_r    <= {TS_WIDTH{1'b0}};
      end else begin
         state_r <= state_s;
         dcnt_r  <= dcnt_s;
         pend_r  <= pend_s;
         ovf_r   <= ovf_s;
         pin_r   <= pin_level(AL, state_s == ST_PULSE);
         busy_r  <= (state_s != ST_IDLE) || (pend_s != PEND_ZERO);
         if (start_s) begin
            cnt_r <= cnt_r + CNT_ONE;
            ts_r  <= ts_now;
         end else begin
            cnt_r <= cnt_r;
            ts_r  <= ts_r;
         end
      end
   end

   assign pmod_pin  = pin_r;
   assign busy      = busy_r;
   assign overflow  = ovf_r;
   assign pulse_cnt = cnt_r;
   assign ts_last   = ts_r;

endmodule

// File: rtl/pmod_timestamp_gen.sv
// Multi-channel EEMBC timestamp pulse generator for PMOD pins.
// Owns the free-running timestamp counter shared by all channels and
// instantiates one independent pmod_ts_channel per pin.
// Ports:
//  sys_clock  in   clock
//  reset      in   asynchronous active-low reset
//  enable     in   global trigger enable
//  trig       in   [NUM_CH]            per-channel trigger
//  clear_ovf  in   [NUM_CH]            per-channel overflow clear
//  pmod_pin   out  [NUM_CH]            registered pulse pins
//  busy       out  [NUM_CH]            channel active or events pending
//  overflow   out  [NUM_CH]            sticky trigger-dropped flag
//  pulse_cnt  out  [NUM_CH*CNT_WIDTH]  pulses started, ch0 in LSBs
//  ts_last    out  [NUM_CH*TS_WIDTH]   timestamp of last pulse start, ch0 in LSBs
module pmod_timestamp_gen
   import pmod_ts_pkg::*;
#(
   parameter int NUM_CH       = 1,
   parameter int PULSE_CYCLES = 100,
   parameter int GAP_CYCLES   = 100,
   parameter int PEND_DEPTH   = 4,
   parameter int TS_WIDTH     = 32,
   parameter int CNT_WIDTH    = 16,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic                        sys_clock,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [NUM_CH-1:0]           trig,
   input  logic [NUM_CH-1:0]           clear_ovf,
   output logic [NUM_CH-1:0]           pmod_pin,
   output logic [NUM_CH-1:0]           busy,
   output logic [NUM_CH-1:0]           overflow,
   output logic [NUM_CH*CNT_WIDTH-1:0] pulse_cnt,
   output logic [NUM_CH*TS_WIDTH-1:0]  ts_last
);

   localparam logic [TS_WIDTH-1:0] TS_ONE = TS_WIDTH'(1);

   logic [TS_WIDTH-1:0] ts_cnt_r;

   // Free-running timestamp, wraps modulo 2^TS_WIDTH.
   always_ff @(posedge sys_clock or negedge reset) begin
      if (!reset) begin
         ts_cnt_r <= {TS_WIDTH{1'b0}};
      end else begin
         ts_cnt_r <= ts_cnt_r + TS_ONE;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      pmod_ts_channel #(
         .PULSE_CYCLES (PULSE_CYCLES),
         .GAP_CYCLES   (GAP_CYCLES),
         .PEND_DEPTH   (PEND_DEPTH),
         .TS_WIDTH     (TS_WIDTH),
         .CNT_WIDTH    (CNT_WIDTH),
         .ACTIVE_LOW   (ACTIVE_LOW)
      ) u_ch (
         .sys_clock (sys_clock),
         .reset     (reset),
         .enable    (enable),
         .trig      (trig[g]),
         .clear_ovf (clear_ovf[g]),
         .ts_now    (ts_cnt_r),
         .pmod_pin  (pmod_pin[g]),
         .busy      (busy[g]),
         .overflow  (overflow[g]),
         .pulse_cnt (pulse_cnt[g*CNT_WIDTH +: CNT_WIDTH]),
         .ts_last   (ts_last[g*TS_WIDTH +: TS_WIDTH])
      );
   end

endmodule

// File: tb/tb_pmod_timestamp_gen.sv
// Scoreboard bench: stimulus pushes the expected pulse starts (start cycle,
// pulse count, timestamp) into a queue; a monitor watching the pins pops and
// checks each start and the width of each pulse. Directed checks cover reset,
// busy, overflow and the enable/reset corner cases.
module tb_pmod_timestamp_gen;

   typedef struct {
      int mon;     // 0,1: dut_a channels, 2: dut_b channel 0
      int start;
      int cnt;
      int ts;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b1;
   logic [1:0]  trig_a = 2'b00;
   logic [1:0]  clr_a = 2'b00;
   logic [1:0]  pin_a, busy_a, ovf_a;
   logic [31:0] cnt_a;
   logic [63:0] ts_a;
   logic [0:0]  trig_b = 1'b0;
   logic [0:0]  clr_b = 1'b0;
   logic [0:0]  pin_b, busy_b, ovf_b;
   logic [15:0] cnt_b;
   logic [31:0] ts_b;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   exp_t sb[$];
   bit   in_p[3];
   int   st[3];

   pmod_timestamp_gen #(.NUM_CH(2)) dut_a (
      .sys_clock(clk), .reset(rst_n), .enable(en), .trig(trig_a), .clear_ovf(clr_a),
      .pmod_pin(pin_a), .busy(busy_a), .overflow(ovf_a), .pulse_cnt(cnt_a), .ts_last(ts_a)
   );

   pmod_timestamp_gen #(.NUM_CH(1), .ACTIVE_LOW(0), .GAP_CYCLES(0), .PULSE_CYCLES(1)) dut_b (
      .sys_clock(clk), .reset(rst_n), .enable(en), .trig(trig_b), .clear_ovf(clr_b),
      .pmod_pin(pin_b), .busy(busy_b), .overflow(ovf_b), .pulse_cnt(cnt_b), .ts_last(ts_b)
   );

   always #5 clk = ~clk;

   // Cycle number equals the DUT timestamp counter value.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
   endtask

   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int m, input int s, input int c, input int t);
      exp_t e;
      e.mon = m; e.start = s; e.cnt = c; e.ts = t;
      sb.push_back(e);
   endtask

   task automatic trig_a_at(input int n, input logic [1:0] mask);
      goto(n);
      trig_a = mask;
      goto(n + 1);
      trig_a = 2'b00;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Monitor: pulse starts are matched against the scoreboard, pulse ends checked for width.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int m = 0; m < 3; m++) in_p[m] = 1'b0;
      end else begin
         for (int m = 0; m < 3; m++) begin
            bit act;
            int idx;
            int c_act;
            int t_act;
            act = (m < 2) ? (pin_a[m] == 1'b0) : (pin_b[0] == 1'b1);
            c_act = (m < 2) ? int'(cnt_a[m*16 +: 16]) : int'(cnt_b);
            t_act = (m < 2) ? int'(ts_a[m*32 +: 32]) : int'(ts_b);
            if (act && !in_p[m]) begin
               in_p[m] = 1'b1;
               st[m] = cyc;
               idx = -1;
               for (int k = 0; k < sb.size(); k++) begin
                  if (idx < 0 && sb[k].mon == m) idx = k;
               end
               if (idx < 0) begin
                  chk($sformatf("unexpected_pulse_mon%0d", m), 64'(cyc), 64'(-1));
               end else begin
                  chk($sformatf("start_cyc_mon%0d", m), 64'(cyc), 64'(sb[idx].start));
                  chk($sformatf("pulse_cnt_mon%0d", m), 64'(c_act), 64'(sb[idx].cnt));
                  chk($sformatf("ts_last_mon%0d", m), 64'(t_act), 64'(sb[idx].ts));
                  sb.delete(idx);
               end
            end else if (!act && in_p[m]) begin
               in_p[m] = 1'b0;
               chk($sformatf("width_mon%0d", m), 64'(cyc - st[m]), 64'((m < 2) ? 100 : 1));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset values
      apply_reset();
      chk("rst_pin_a", 64'(pin_a), 64'(2'b11));
      chk("rst_pin_b", 64'(pin_b), 64'(1'b0));
      chk("rst_busy_a", 64'(busy_a), 64'd0);
      chk("rst_ovf_a", 64'(ovf_a), 64'd0);
      chk("rst_cnt_a", 64'(cnt_a), 64'd0);
      chk("rst_ts_a", ts_a, 64'd0);

      // Single trigger on ch0 at cycle 10; then simultaneous start on both channels
      push(0, 11, 1, 10);
      trig_a_at(10, 2'b01);
      goto(110); chk("pin0_last_low", 64'(pin_a[0]), 64'd0);
      goto(111); chk("pin0_high_again", 64'(pin_a[0]), 64'd1);
      chk("pin1_idle", 64'(pin_a[1]), 64'd1);
      chk("busy0_in_gap", 64'(busy_a[0]), 64'd1);
      push(0, 301, 2, 300);
      push(1, 301, 1, 300);
      trig_a_at(300, 2'b11);
      goto(520);
      chk("sb_empty_t1", 64'(sb.size()), 64'd0);

      // Three triggers: one direct start, two queued
      apply_reset();
      push(0, 11, 1, 10);
      push(0, 212, 2, 211);
      push(0, 413, 3, 412);
      trig_a_at(10, 2'b01);
      trig_a_at(20, 2'b01);
      trig_a_at(30, 2'b01);
      goto(612); chk("busy0_612", 64'(busy_a[0]), 64'd1);
      goto(613); chk("busy0_613", 64'(busy_a[0]), 64'd0);
      chk("sb_empty_t2", 64'(sb.size()), 64'd0);

      // Queue fills to 4, sixth trigger overflows; clear vs same-cycle drop
      apply_reset();
      push(0, 11, 1, 10);
      push(0, 212, 2, 211);
      push(0, 413, 3, 412);
      push(0, 614, 4, 613);
      push(0, 815, 5, 814);
      trig_a_at(10, 2'b01);
      for (int i = 20; i < 24; i++) trig_a_at(i, 2'b01);
      goto(24); chk("ovf_before_drop", 64'(ovf_a[0]), 64'd0);
      trig_a_at(24, 2'b01);
      chk("ovf_after_drop", 64'(ovf_a[0]), 64'd1);
      goto(30);
      trig_a = 2'b01; clr_a = 2'b01;
      goto(31);
      trig_a = 2'b00;
      chk("ovf_set_beats_clear", 64'(ovf_a[0]), 64'd1);
      goto(32);
      clr_a = 2'b00;
      chk("ovf_cleared", 64'(ovf_a[0]), 64'd0);
      chk("ovf1_untouched", 64'(ovf_a[1]), 64'd0);
      goto(1030);
      chk("busy0_after_queue", 64'(busy_a[0]), 64'd0);
      chk("sb_empty_t3", 64'(sb.size()), 64'd0);

      // Disable with two pending: current pulse completes, queue flushed
      apply_reset();
      push(0, 11, 1, 10);
      trig_a_at(10, 2'b01);
      trig_a_at(20, 2'b01);
      trig_a_at(30, 2'b01);
      goto(50); en = 1'b0;
      trig_a_at(150, 2'b01);
      goto(210); chk("busy0_gap_disabled", 64'(busy_a[0]), 64'd1);
      goto(211); chk("busy0_idle_disabled", 64'(busy_a[0]), 64'd0);
      trig_a_at(250, 2'b11);
      goto(260);
      chk("cnt0_disabled", 64'(cnt_a[15:0]), 64'd1);
      chk("ovf_disabled", 64'(ovf_a), 64'd0);
      chk("busy_disabled", 64'(busy_a), 64'd0);
      en = 1'b1;
      chk("sb_empty_t4", 64'(sb.size()), 64'd0);

      // Asynchronous reset mid-pulse
      apply_reset();
      push(0, 11, 1, 10);
      trig_a_at(10, 2'b01);
      goto(60);
      rst_n = 1'b0;
      #1;
      chk("async_rst_pin", 64'(pin_a), 64'(2'b11));
      chk("async_rst_cnt", 64'(cnt_a), 64'd0);
      chk("async_rst_ts", ts_a, 64'd0);
      chk("async_rst_busy", 64'(busy_a), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      push(0, 11, 1, 10);
      trig_a_at(10, 2'b01);
      goto(15); chk("cnt0_after_rst", 64'(cnt_a[15:0]), 64'd1);
      goto(230);
      chk("sb_empty_t5", 64'(sb.size()), 64'd0);

      // dut_b: active-high, no gap, 1-cycle pulses; trig held 3 cycles
      apply_reset();
      push(2, 11, 1, 10);
      push(2, 13, 2, 12);
      push(2, 15, 3, 14);
      goto(10); trig_b = 1'b1;
      goto(13); trig_b = 1'b0;
      goto(25);
      chk("b_cnt", 64'(cnt_b), 64'd3);
      chk("b_busy", 64'(busy_b), 64'd0);
      chk("b_ovf", 64'(ovf_b), 64'd0);
      chk("b_pin_idle", 64'(pin_b), 64'd0);
      chk("sb_empty_t6", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
